// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states and boot-constant table for data_memory_pipe.
package dmem_pkg;
    typedef enum logic {INIT, RUN} state_e;
    localparam int BOOT_COUNT = 4;
    localparam int BOOT_W = $clog2(BOOT_COUNT);
    localparam logic [7:0] BOOT_TABLE [BOOT_COUNT] = '{8'd10, 8'd7, 8'd75, 8'd9};
    function automatic logic [7:0] boot_value(input int unsigned addr, input int unsigned base);
        return (addr >= base && addr < base + BOOT_COUNT) ? BOOT_TABLE[BOOT_W'(addr - base)] : 8'd0;
    endfunction
endpackage

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe: LAT-deep valid/data/err shift register; data stages only load on valid so the output holds.
module dmem_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              err_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);
    logic [LAT-1:0] v_q, v_d, e_q, e_d;
    logic [LAT-1:0][DATA_W-1:0] d_q, d_d;
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        e_d = e_q;
        for (int i = 0; i < LAT; i++) begin
            v_d[i] = (i == 0) ? valid_i : v_q[(i == 0) ? 0 : i - 1];
            d_d[i] = v_d[i] ? ((i == 0) ? data_i : d_q[(i == 0) ? 0 : i - 1]) : d_q[i];
            e_d[i] = v_d[i] ? ((i == 0) ? err_i : e_q[(i == 0) ? 0 : i - 1]) : e_q[i];
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            d_q <= '0;
            e_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
            e_q <= e_d;
        end
    end
    assign valid_o = v_q[LAT-1];
    assign data_o  = d_q[LAT-1];
    assign err_o   = e_q[LAT-1];
endmodule

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: sync-write, pipelined-read RAM with a boot-time init sequencer.
// Requests are only accepted once the init sweep has rewritten every word.
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 1,
    parameter int INIT_BASE = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    state_e state_q, state_d;
    logic [PW-1:0] init_ptr_q, init_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic in_range, accept;
    logic [DATA_W-1:0] rd_data;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end
    always_comb begin
        state_d    = (state_q == INIT && init_ptr_q == LAST) ? RUN : state_q;
        init_ptr_d = (state_q == INIT) ? init_ptr_q + 1'b1 : init_ptr_q;
    end
    assign req_ready = state_q == RUN;
    assign init_done = state_q == RUN;
    assign accept    = req_valid && req_ready;
    // One extra bit so DEPTH == 2**ADDR_W compares correctly.
    assign in_range  = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
    assign rd_data   = in_range ? mem[req_addr[PW-1:0]] : '0;
    always_ff @(posedge clock) begin
        if (state_q == INIT)
            mem[init_ptr_q] <= DATA_W'(boot_value(32'(init_ptr_q), INIT_BASE));
        else if (accept && req_write && in_range)
            mem[req_addr[PW-1:0]] <= req_wdata;
    end
    dmem_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LAT)) u_rd_pipe (
        .clock   (clock),
        .reset   (reset),
        .valid_i (accept && !req_write),
        .data_i  (rd_data),
        .err_i   (!in_range),
        .valid_o (rsp_valid),
        .data_o  (rsp_data),
        .err_o   (rsp_err)
    );
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: instance A (DEPTH=128, READ_LAT=3) checked every cycle against a queue model,
// instance B (DEPTH=256, READ_LAT=1) checked with directed literals.
module tb_data_memory_pipe;
    localparam int A_DEPTH = 128;
    localparam int A_LAT = 3;
    logic clock = 0;
    logic reset;
    logic a_valid, a_ready, a_write, a_rsp_valid, a_rsp_err, a_init_done;
    logic [7:0] a_addr, a_wdata, a_rsp_data;
    logic b_valid, b_ready, b_write, b_rsp_valid, b_rsp_err, b_init_done;
    logic [7:0] b_addr, b_wdata, b_rsp_data;
    int total = 0;
    int bad = 0;
    always #5 clock = ~clock;

    data_memory_pipe #(.DATA_W(8), .ADDR_W(8), .DEPTH(A_DEPTH), .READ_LAT(A_LAT), .INIT_BASE(100)) dut_a (
        .clock(clock), .reset(reset), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
        .rsp_err(a_rsp_err), .init_done(a_init_done));
    data_memory_pipe #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .READ_LAT(1), .INIT_BASE(100)) dut_b (
        .clock(clock), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .rsp_err(b_rsp_err), .init_done(b_init_done));

    // Model of A: word image, init countdown, and a queue of responses tagged with their due edge.
    typedef struct {int due; int d; int e;} exp_t;
    typedef struct {int d; int e; int c;} rsp_t;
    int boot [4] = '{10, 7, 75, 9};
    logic [7:0] mm [256];
    exp_t q [$];
    int ecnt = 0;
    int icnt, m_d, m_e;
    bit m_ready, m_v;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ready = 0;
            icnt = 0;
            m_v = 0;
            m_d = 0;
            m_e = 0;
            for (int i = 0; i < 256; i++) begin
                mm[i] = 8'd0;
                if (i >= 100 && i < 104) mm[i] = 8'(boot[i - 100]);
            end
        end else begin
            ecnt++;
            if (!m_ready) begin
                icnt++;
                m_ready = icnt == A_DEPTH;
            end else if (a_valid) begin
                if (a_write) begin
                    if (int'(a_addr) < A_DEPTH) mm[a_addr] = a_wdata;
                end else
                    q.push_back('{ecnt + A_LAT - 1, int'(a_addr) < A_DEPTH ? int'(mm[a_addr]) : 0,
                                  int'(int'(a_addr) >= A_DEPTH)});
            end
            m_v = q.size() > 0 && q[0].due == ecnt;
            if (m_v) begin
                m_d = q[0].d;
                m_e = q[0].e;
                void'(q.pop_front());
            end
        end
    end

    rsp_t a_log [$];
    rsp_t b_log [$];

    task automatic lit(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic a_op(input bit w, input int addr, input int data);
        a_valid = 1;
        a_write = w;
        a_addr = 8'(addr);
        a_wdata = 8'(data);
        @(posedge clock);
        #1 a_valid = 0;
    endtask

    task automatic b_op(input bit w, input int addr, input int data);
        b_valid = 1;
        b_write = w;
        b_addr = 8'(addr);
        b_wdata = 8'(data);
        @(posedge clock);
        #1 b_valid = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic int lg_d(input rsp_t l [$], input int i);
        return l.size() > i ? l[i].d : -1;
    endfunction

    function automatic int lg_e(input rsp_t l [$], input int i);
        return l.size() > i ? l[i].e : -1;
    endfunction

    initial begin
        int at, bt, k;
        reset = 1;
        {a_valid, a_write, a_addr, a_wdata} = '0;
        {b_valid, b_write, b_addr, b_wdata} = '0;
        fork
            forever begin
                @(negedge clock);
                lit("a_req_ready", int'(a_ready), int'(m_ready));
                lit("a_init_done", int'(a_init_done), int'(m_ready));
                lit("a_rsp_valid", int'(a_rsp_valid), int'(m_v));
                lit("a_rsp_data", int'(a_rsp_data), m_d);
                lit("a_rsp_err", int'(a_rsp_err), m_e);
                if (a_rsp_valid) a_log.push_back('{int'(a_rsp_data), int'(a_rsp_err), ecnt});
                if (b_rsp_valid) b_log.push_back('{int'(b_rsp_data), int'(b_rsp_err), ecnt});
            end
        join_none
        tick(2);
        lit("rst_a_ready", int'(a_ready), 0);
        lit("rst_a_rsp_valid", int'(a_rsp_valid), 0);
        lit("rst_a_rsp_data", int'(a_rsp_data), 0);
        lit("rst_a_rsp_err", int'(a_rsp_err), 0);
        lit("rst_a_init_done", int'(a_init_done), 0);
        lit("rst_b_init_done", int'(b_init_done), 0);
        // A read of 101 is held through INIT and must be taken on the first RUN cycle.
        a_valid = 1;
        a_write = 0;
        a_addr = 8'd101;
        reset = 0;
        at = 0;
        bt = 0;
        for (int i = 1; i <= 400 && bt == 0; i++) begin
            @(posedge clock);
            #1;
            if (a_init_done && at == 0) at = i;
            if (b_init_done && bt == 0) bt = i;
            if (at != 0 && i == at + 1) a_valid = 0;
        end
        lit("a_init_cycles", at, 128);
        lit("b_init_cycles", bt, 256);
        lit("held_read_count", a_log.size(), 1);
        lit("held_read_data", lg_d(a_log, 0), 7);
        lit("held_read_err", lg_e(a_log, 0), 0);

        a_log.delete();
        a_op(1, 'h20, 'hA5);
        a_op(0, 'h20, 0);
        k = 0;
        while (!a_rsp_valid && k < 10) begin
            @(posedge clock);
            #1;
            k++;
        end
        lit("read_latency_edges", k + 1, 3);
        lit("raw_hazard_data", int'(a_rsp_data), 'hA5);

        tick(2);
        a_log.delete();
        for (int i = 0; i < 4; i++) a_op(0, 100 + i, 0);
        tick(5);
        lit("b2b_count", a_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            lit("b2b_data", lg_d(a_log, i), boot[i]);
            lit("b2b_err", lg_e(a_log, i), 0);
            if (a_log.size() == 4) lit("b2b_back_to_back", a_log[i].c - a_log[0].c, i);
        end

        a_log.delete();
        a_op(1, 'h80, 'h55);
        a_op(0, 'h80, 0);
        a_op(0, 'h00, 0);
        a_op(0, 'h7F, 0);
        tick(5);
        lit("oor_count", a_log.size(), 3);
        lit("oor_data", lg_d(a_log, 0), 0);
        lit("oor_err", lg_e(a_log, 0), 1);
        lit("no_alias_data", lg_d(a_log, 1), 0);
        lit("no_alias_err", lg_e(a_log, 1), 0);
        lit("last_word_err", lg_e(a_log, 2), 0);

        b_log.delete();
        b_op(0, 255, 0);
        lit("b_lat1_valid", int'(b_rsp_valid), 1);
        b_op(1, 255, 'hC3);
        b_op(0, 255, 0);
        b_op(0, 100, 0);
        tick(3);
        lit("b_count", b_log.size(), 3);
        lit("b_top_init", lg_d(b_log, 0), 0);
        lit("b_top_err", lg_e(b_log, 0), 0);
        lit("b_top_write", lg_d(b_log, 1), 'hC3);
        lit("b_boot100", lg_d(b_log, 2), 10);

        a_log.delete();
        a_op(1, 100, 'h33);
        a_op(0, 100, 0);
        tick(4);
        lit("overwrite_100", lg_d(a_log, 0), 'h33);
        a_log.delete();
        a_op(0, 101, 0);
        a_op(0, 102, 0);
        reset = 1;
        tick(4);
        lit("flushed_rsp_count", a_log.size(), 0);
        lit("flushed_rsp_valid", int'(a_rsp_valid), 0);
        reset = 0;
        k = 0;
        while (!a_init_done && k < 300) begin
            @(posedge clock);
            #1;
            k++;
        end
        lit("reinit_cycles", k, 128);
        a_op(0, 100, 0);
        tick(4);
        lit("reinit_count", a_log.size(), 1);
        lit("reinit_100", lg_d(a_log, 0), 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
- Parametrised successor to the single-cycle 8-bit data memory: synchronous-write, pipelined-read RAM with a valid/ready request port and a valid response port.
- After reset, a built-in init sequencer clears every word and loads the fixed boot constants (10, 7, 75, 9 at 100..103), so the program image is deterministic without a clock-level preload block.
- Sits between the datapath's MEM stage and the register write-back mux.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 8, request address width.
- DEPTH, 256, number of words; must be <= 2**ADDR_W.
- READ_LAT, 1, read latency in cycles from request accept to rsp_valid; legal range 1..4.
- INIT_BASE, 100, address of the first boot constant.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid, one-cycle pulse per accepted read.
- rsp_data  out  DATA_W  read data.
- rsp_err  out  1  qualifies rsp_valid: the address was >= DEPTH.
- init_done  out  1  high once the init sequence has completed.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0. The FSM goes to INIT with init_ptr=0 and the read pipeline is cleared.
- FSM states:
  - INIT: writes word[init_ptr] = boot_value(init_ptr) each cycle. boot_value is the constant table entry for INIT_BASE..INIT_BASE+3, else 0. At init_ptr==DEPTH-1 it writes, then moves to RUN.
  - INIT takes exactly DEPTH cycles after reset deassert.
  - RUN: req_ready=1 and init_done=1 from the first RUN cycle. RUN has no exit except reset.
- Accept rule: a request is accepted on a rising edge with req_valid && req_ready. At most one request per cycle; there is no backpressure on responses.
- Write: takes effect at the accept edge. If req_addr >= DEPTH, the write is silently dropped. Writes produce no response.
- Read:
  - Memory is sampled at the accept edge, then delayed through READ_LAT-1 registered stages.
  - rsp_valid is asserted exactly READ_LAT cycles after the accept edge, for one cycle.
  - Out-of-range reads give rsp_data=0, rsp_err=1; otherwise rsp_err=0.
  - rsp_data holds its last value when rsp_valid=0.
- Ordering and hazards:
  - A read accepted the cycle after a write to the same address returns the new data.
  - Responses come back in request order. With back-to-back reads, throughput is 1 per cycle.
- Boundaries:
  - Address DEPTH-1 is valid; DEPTH is an error.
  - When DEPTH < 2**ADDR_W, upper addresses never alias.
  - init_ptr is DEPTH-wide and must not overflow at DEPTH=2**ADDR_W.
- Reset mid-operation (INIT or RUN, with reads in flight): the pipeline is flushed, no rsp_valid is issued for flushed reads, memory contents are rebuilt by a full re-INIT, and pending writes are not applied.
- Requests presented during INIT are ignored (req_ready=0); the master must hold them.
- Memory array needs no reset; only the FSM, pointer and pipeline registers are reset.

Decomposition:
- Shared package dmem_pkg holds:
  - the FSM state enum {INIT, RUN};
  - BOOT_COUNT=4;
  - the BOOT_TABLE constant array {10, 7, 75, 9};
  - the boot_value(addr) function.
- One natural sub-module: dmem_rd_pipe, a READ_LAT-deep valid/data/err shift register with async clear.

Test Plan:
- Release reset, count cycles -> init_done rises exactly DEPTH cycles later. Reads of 100..103 return 10, 7, 75, 9 with rsp_err=0; read of 0 returns 0.
- READ_LAT=3: write 0xA5 to 0x20, next cycle read 0x20 -> rsp_valid exactly 3 cycles after the read accept, rsp_data=0xA5.
- Back-to-back reads of 100, 101, 102, 103 -> four consecutive rsp_valid pulses in order: 10, 7, 75, 9.
- DEPTH=128: write 0x55 to 0x80, then read 0x80 -> rsp_err=1, rsp_data=0; read 0x00 still returns 0 (no aliasing). Read 0x7F -> rsp_err=0.
- Assert reset while 2 reads are in flight -> no rsp_valid pulse. Earlier write of 0x33 to 100 is gone: after re-init, read 100 returns 10.
- Hold req_valid=1 during INIT -> req_ready=0 and no write/response occur. The request is accepted on the first RUN cycle.
